// File: rtl/uart.sv
// Transmit-only 8N1 UART serializer with an internal bit-rate counter.
// Bit timing restarts at frame acceptance, so every bit is exactly
// BIT_CYCLES clocks wide regardless of when start arrives.
//
// state | meaning
// IDLE  | line high, waiting for start
// START | start bit (tx=0) for BIT_CYCLES clocks
// DATA  | eight data bits, LSB first, BIT_CYCLES clocks each
// STOP  | stop bit (tx=1); tx_done pulses as it completes
module uart #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int BIT_CYCLES = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  // last clock of the current bit period
  assign bit_end = (cyc_cnt == LAST_CYC);

  // frame sequencer; tx is always taken from a register so the line never glitches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (start) begin
            shreg   <= tx_data;
            cyc_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// Directed bench for the uart serializer: a short-bit instance for frame
// content and handshake behaviour, and a default-rate instance for bit timing.
module tb_uart;

  localparam int BC = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic [7:0] tx_data;
  logic       tx, tx_busy, tx_done;

  logic       reset_d, start_d;
  logic [7:0] data_d;
  logic       tx_d, busy_d, done_d;

  uart #(.BIT_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart dut_def (
    .clk(clk), .reset(reset_d), .start(start_d), .tx_data(data_d),
    .tx(tx_d), .tx_busy(busy_d), .tx_done(done_d)
  );

  int checks = 0;
  int errors = 0;

  logic tx_s   [0:100];
  logic busy_s [0:100];
  logic done_s [0:100];

  // expected line level k cycles after acceptance (k=0 is the first start-bit cycle)
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    int b;
    b = k / BC;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // record outputs for frame cycles 0..100; caller is positioned at cycle 0
  task automatic capture();
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) @(negedge clk);
      tx_s[k]   = tx;
      busy_s[k] = tx_busy;
      done_s[k] = tx_done;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_hold got tx/busy/done=%b%b%b want 100", tx, tx_busy, tx_done);
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, tx_busy, tx_done} !== 3'b100) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %b%b%b want 100", i, tx, tx_busy, tx_done);
      end
    end
  endtask

  task automatic test_default_rate();
    int len;
    logic ev;
    reset_d = 1'b1;
    @(negedge clk);
    start_d = 1'b1; data_d = 8'h55;
    @(negedge clk);
    start_d = 1'b0;
    checks++;
    if (busy_d !== 1'b1) begin
      errors++;
      $display("FAIL def_busy got %b want 1", busy_d);
    end
    // start bit, then data bits 0 and 1 of 8'h55 (1, 0)
    for (int r = 0; r < 3; r++) begin
      ev = (r == 0) ? 1'b0 : ((r == 1) ? 1'b1 : 1'b0);
      checks++;
      if (tx_d !== ev) begin
        errors++;
        $display("FAIL def_level run %0d got %b want %b", r, tx_d, ev);
      end
      len = 0;
      while (tx_d === ev && len < 12000) begin
        len++;
        @(negedge clk);
      end
      checks++;
      if (len != 10416) begin
        errors++;
        $display("FAIL def_period run %0d got %0d want 10416", r, len);
      end
    end
    checks++;
    if (tx_d !== 1'b1) begin
      errors++;
      $display("FAIL def_bit2 got %b want 1", tx_d);
    end
    reset_d = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int bad;
    @(negedge clk);
    start = 1'b1; tx_data = 8'hCA;
    @(negedge clk);
    start = 1'b0;
    capture();
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (tx_s[k] !== exp_bit(8'hCA, k) || busy_s[k] !== 1'b1 || done_s[k] !== 1'b0) begin
        errors++; bad++;
        if (bad < 4)
          $display("FAIL single_frame k=%0d got tx/busy/done=%b%b%b want %b10",
                   k, tx_s[k], busy_s[k], done_s[k], exp_bit(8'hCA, k));
      end
    end
    checks++;
    if ({tx_s[100], busy_s[100], done_s[100]} !== 3'b101) begin
      errors++;
      $display("FAIL single_end got %b%b%b want 101", tx_s[100], busy_s[100], done_s[100]);
    end
    @(negedge clk);
    checks++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL single_done_width got %b%b%b want 100", tx, tx_busy, tx_done);
    end
  endtask

  task automatic test_ignore_busy();
    int bad;
    @(negedge clk);
    start = 1'b1; tx_data = 8'hCA;
    @(negedge clk);
    start = 1'b0;
    fork
      capture();
      begin
        repeat (35) @(negedge clk);
        start = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
      end
    join
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (tx_s[k] !== exp_bit(8'hCA, k) || busy_s[k] !== 1'b1) begin
        errors++; bad++;
        if (bad < 4)
          $display("FAIL ignore_frame k=%0d got tx/busy=%b%b want %b1",
                   k, tx_s[k], busy_s[k], exp_bit(8'hCA, k));
      end
    end
    checks++;
    if (done_s[100] !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done got %b want 1", done_s[100]);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, tx_busy, tx_done} !== 3'b100) begin
        errors++;
        $display("FAIL ignore_no_second cyc %0d got %b%b%b want 100", i, tx, tx_busy, tx_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    @(negedge clk);
    start = 1'b1; tx_data = 8'h00;
    @(negedge clk);
    fork
      capture();
      begin
        repeat (50) @(negedge clk);
        tx_data = 8'hFF;
      end
    join
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (tx_s[k] !== exp_bit(8'h00, k) || busy_s[k] !== 1'b1) begin
        errors++; bad++;
        if (bad < 4)
          $display("FAIL b2b_first k=%0d got tx/busy=%b%b want %b1",
                   k, tx_s[k], busy_s[k], exp_bit(8'h00, k));
      end
    end
    checks++;
    if ({tx_s[100], busy_s[100], done_s[100]} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_gap got %b%b%b want 101", tx_s[100], busy_s[100], done_s[100]);
    end
    @(negedge clk);
    start = 1'b0;
    capture();
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (tx_s[k] !== exp_bit(8'hFF, k) || busy_s[k] !== 1'b1) begin
        errors++; bad++;
        if (bad < 4)
          $display("FAIL b2b_second k=%0d got tx/busy=%b%b want %b1",
                   k, tx_s[k], busy_s[k], exp_bit(8'hFF, k));
      end
    end
    checks++;
    if (done_s[100] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done got %b want 1", done_s[100]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    start = 1'b1; tx_data = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    repeat (42) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got tx/busy=%b%b want 01", tx, tx_busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL rmid_async got %b%b%b want 100", tx, tx_busy, tx_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx_done !== 1'b0) begin
        errors++;
        $display("FAIL rmid_no_done cyc %0d got %b want 0", i, tx_done);
      end
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL rmid_idle got %b%b%b want 100", tx, tx_busy, tx_done);
    end
    start = 1'b1; tx_data = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    capture();
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (tx_s[k] !== exp_bit(8'h3C, k) || busy_s[k] !== 1'b1 || done_s[k] !== 1'b0) begin
        errors++; bad++;
        if (bad < 4)
          $display("FAIL rmid_fresh k=%0d got tx/busy/done=%b%b%b want %b10",
                   k, tx_s[k], busy_s[k], done_s[k], exp_bit(8'h3C, k));
      end
    end
    checks++;
    if ({tx_s[100], busy_s[100], done_s[100]} !== 3'b101) begin
      errors++;
      $display("FAIL rmid_fresh_end got %b%b%b want 101", tx_s[100], busy_s[100], done_s[100]);
    end
  endtask

  initial begin
    reset_d = 1'b0; start_d = 1'b0; data_d = 8'h00;
    test_reset();
    test_default_rate();
    test_single_frame();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- Transmit-only UART serializer with an internal bit-rate generator, 8N1 framing (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
- Sits between a byte-producing controller (start/tx_data handshake) and the serial TX pin.
- Reports activity on tx_busy and completion on a single-cycle tx_done pulse.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate in bits/s.
- BIT_CYCLES, CLK_FREQ/BAUD (integer division, 10416 at defaults), clock cycles per serial bit. Derived, overridable for simulation; legal range ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to transmit tx_data; sampled on rising clk.
- tx_data  input  8  byte to transmit; captured when start is accepted.
- tx  output  1  serial line; idle level 1.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, tx_busy=0, tx_done=0, bit counter=0, cycle counter=0, shift register=0. All outputs are registered.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, tx_busy=0.
  - On a clk edge with start=1, latch tx_data into the shift register, clear the cycle counter, go to START.
  - On the following cycle, tx=0 and tx_busy=1.
- START:
  - tx=0 for exactly BIT_CYCLES clocks, then go to DATA with bit index 0.
- DATA:
  - tx = shift register bit[index], LSB first, each bit held BIT_CYCLES clocks.
  - After bit 7 completes, go to STOP.
- STOP:
  - tx=1 for BIT_CYCLES clocks.
  - On the last cycle of the stop bit, assert tx_done for exactly one clock and return to IDLE (tx_busy=0 from that next cycle).
- Cycle counter:
  - Counts 0..BIT_CYCLES-1 within each bit and restarts at 0 on every bit boundary and on frame start.
  - The bit timing is therefore aligned to start acceptance, not to a free-running tick.
- Frame length: exactly 10*BIT_CYCLES clocks from the first cycle of tx=0 to the first idle cycle after the stop bit.
- start while tx_busy=1 (including during the STOP state): ignored; no queuing, latched data unaffected.
- start held high continuously: a new frame is accepted on the first IDLE cycle after tx_done (back-to-back frames, one idle cycle between stop and next start bit).
- tx_data changes after acceptance: no effect on the frame in flight.
- Reset mid-frame: frame aborted immediately, tx returns to 1, tx_busy=0, no tx_done.
- tx has no glitches: it is driven from a register, and it changes only on bit boundaries.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> tx=1, tx_busy=0, tx_done=0; with start=0 the outputs stay idle indefinitely.
- Single frame, BIT_CYCLES=10 (override), tx_data=8'hCA, start pulsed 1 cycle:
  - tx sequence per 10-cycle bit = 0 | 0,1,0,1,0,0,1,1 | 1.
  - tx_busy high for 100 cycles.
  - tx_done high for exactly 1 cycle at the end of the stop bit.
- Default parameters, tx_data=8'h55 -> each bit period measures 10416 clocks (104.16 µs at 10 ns clock); serial line decodes 8'h55.
- start re-pulsed with tx_data=8'hFF mid-frame of 8'hCA -> the 8'hCA frame completes unchanged, and no second frame starts.
- start held high with tx_data=8'h00 then 8'hFF -> two back-to-back frames; the second frame carries the value present on tx_data at its acceptance cycle.
- reset asserted during the DATA state of a frame -> tx=1 and tx_busy=0 asynchronously; no tx_done pulse; the next start sends a complete fresh frame.
